button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Conditions raw, bouncy push-button inputs into clean levels and one-cycle press/release pulses.
- Sits directly upstream of the clock speed switcher and its faster/slower button inputs, plus any other button-driven control logic.
- Each channel has a 2-FF synchronizer, a stability counter and a 4-state FSM.
- With the optional auto-repeat compiled in, a held button emits periodic press pulses, so the clock level can be stepped by holding a button.

Parameters:
- WIDTH, 2, number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 999_999, cycles the synchronized input must stay stable before a change is accepted (>=1; 10 ms at 100 MHz).
- REPEAT_DELAY, 49_999_999, cycles spent in PRESSED before the first repeat pulse. Used only with AUTO_REPEAT_EN.
- REPEAT_PERIOD, 9_999_999, cycles between subsequent repeat pulses (>=1). Used only with AUTO_REPEAT_EN.

Ports:
- clk, input, 1, system clock, fastest available.
- rst_n, input, 1, asynchronous active-low reset.
- btn_raw, input, WIDTH, raw asynchronous button levels, active-high.
- btn_level, output, WIDTH, debounced button level, registered.
- btn_press, output, WIDTH, one-cycle pulse on an accepted press (and on repeats, if enabled).
- btn_release, output, WIDTH, one-cycle pulse on an accepted release.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all synchronizer flops, counters and outputs go to 0;
  - every FSM goes to RELEASED.
- Reset deassertion is used as-is; no internal reset synchronizer.
- Channels are fully independent. Simultaneous activity on several channels is handled in parallel with no priority.
- Synchronizer: s = btn_raw after 2 flops.
- Stability counter: width $clog2(DEBOUNCE_CYCLES+1), one per channel. Zeroed on every state entry.
- FSM states and transitions:
  - RELEASED: if s=1, go to CHECK_PRESS with cnt<=0.
  - CHECK_PRESS:
    - if s=0, go to RELEASED (bounce rejected, no output);
    - else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED with btn_level<=1 and btn_press<=1 for one cycle;
    - else cnt++.
  - PRESSED: if s=0, go to CHECK_RELEASE with cnt<=0.
  - CHECK_RELEASE:
    - if s=1, go back to PRESSED (no output, btn_level stays 1);
    - else if cnt==DEBOUNCE_CYCLES-1, go to RELEASED with btn_level<=0 and btn_release<=1 for one cycle;
    - else cnt++.
- Latency: if btn_raw is first sampled high at edge k and stays high, btn_press and btn_level are high after edge k+DEBOUNCE_CYCLES+2. Release is symmetric.
- Any glitch shorter than the window restarts the whole window. There is no partial credit.
- btn_press and btn_release are never both high on one channel in the same cycle.
- A pulse is never wider than 1 cycle.
- Reset mid-press: outputs drop immediately. If the button is still held after reset, it is re-debounced and yields a fresh btn_press.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_AUTO_REPEAT_EN.
- Defined:
  - in PRESSED, a repeat counter (32-bit, zeroed on PRESSED entry) counts cycles;
  - one extra btn_press pulse after REPEAT_DELAY cycles in PRESSED, then one every REPEAT_PERIOD cycles while the state remains PRESSED;
  - the counter freezes while in CHECK_RELEASE;
  - the counter resumes without reset if the FSM returns to PRESSED from CHECK_RELEASE;
  - the counter clears on entering RELEASED.
- Undefined:
  - exactly one btn_press per accepted press;
  - REPEAT_DELAY and REPEAT_PERIOD are ignored;
  - no repeat logic is synthesized.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, WIDTH=2.
1. Clean press: btn_raw[0] rises at edge k and is held -> btn_press[0] high for exactly 1 cycle after edge k+6; btn_level[0]=1 from then on; channel 1 stays all 0.
2. Bounce: btn_raw[0] toggles 1,0,1,0,1 with 2-cycle phases, then holds 1 -> exactly one btn_press[0], at 6 edges after the final rise; no btn_release.
3. Release with glitch: from PRESSED, drive 0 for 3 cycles, 1 for 1 cycle, then hold 0 -> btn_level stays 1 through the glitch; one btn_release 6 edges after the final fall.
4. Simultaneous: both channels rise on the same edge -> btn_press=2'b11 in the same cycle; releases on both channels are likewise independent.
5. Reset mid-press: assert rst_n=0 while btn_level[1]=1 -> outputs go to 0 immediately. Deassert with the button still held -> a new btn_press[1] after 6 edges.
6. Auto-repeat: hold btn_raw[0] for 30 cycles after the accepted press.
   - With macro: btn_press pulses at offsets 0, 10, 13, 16, 19, 22, 25, 28 relative to the first pulse.
   - Without macro: a single pulse only.

Source files
------------

// File: rtl/button_debouncer.sv
// Per-channel push-button conditioner: 2-FF synchronizer, stability counter and 4-state FSM.
// Define BUTTON_DEBOUNCER_AUTO_REPEAT_EN to add auto-repeat press pulses while a button is held.
module button_debouncer #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 999_999,
  parameter int REPEAT_DELAY    = 49_999_999,
  parameter int REPEAT_PERIOD   = 9_999_999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED      = 2'd0,
    CHECK_PRESS   = 2'd1,
    PRESSED       = 2'd2,
    CHECK_RELEASE = 2'd3
  } state_e;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic          sync1_q, sync2_q;
      state_e        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          level_q, level_d;
      logic          press_q, press_d;
      logic          release_q, release_d;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
      localparam logic [31:0] RPT_FIRST = 32'(REPEAT_DELAY);
      localparam logic [31:0] RPT_STEP  = 32'(REPEAT_PERIOD);
      // rpt counts cycles spent in PRESSED; due is the cycle count of the next repeat pulse.
      logic [31:0]   rpt_q, rpt_d;
      logic [31:0]   due_q, due_d;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
        end else begin
          sync1_q <= btn_raw[gi];
          sync2_q <= sync1_q;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q   <= RELEASED;
          cnt_q     <= '0;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
          rpt_q     <= '0;
          due_q     <= '0;
`endif
        end else begin
          state_q   <= state_d;
          cnt_q     <= cnt_d;
          level_q   <= level_d;
          press_q   <= press_d;
          release_q <= release_d;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
          rpt_q     <= rpt_d;
          due_q     <= due_d;
`endif
        end
      end

      always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
        rpt_d     = rpt_q;
        due_d     = due_q;
`endif
        case (state_q)
          RELEASED: begin
            if (sync2_q) begin
              state_d = CHECK_PRESS;
              cnt_d   = '0;
            end
          end
          CHECK_PRESS: begin
            if (!sync2_q) begin
              state_d = RELEASED;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = PRESSED;
              cnt_d   = '0;
              level_d = 1'b1;
              press_d = 1'b1;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
              rpt_d   = '0;
              due_d   = RPT_FIRST;
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          PRESSED: begin
            if (!sync2_q) begin
              state_d = CHECK_RELEASE;
              cnt_d   = '0;
            end
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
            else begin
              rpt_d = rpt_q + 32'd1;
              if (rpt_d == due_q) begin
                press_d = 1'b1;
                due_d   = due_q + RPT_STEP;
              end
            end
`endif
          end
          CHECK_RELEASE: begin
            // A bounce back to 1 resumes PRESSED; the repeat counter stays frozen meanwhile.
            if (sync2_q) begin
              state_d = PRESSED;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d   = RELEASED;
              cnt_d     = '0;
              level_d   = 1'b0;
              release_d = 1'b1;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
              rpt_d     = '0;
              due_d     = '0;
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = RELEASED;
            cnt_d   = '0;
          end
        endcase
      end

      assign btn_level[gi]   = level_q;
      assign btn_press[gi]   = press_q;
      assign btn_release[gi] = release_q;
    end
  endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer; pulse events are predicted into a queue and matched by a monitor.
// Honours BUTTON_DEBOUNCER_AUTO_REPEAT_EN to predict repeat pulses.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  typedef struct {
    int         edge_no;
    logic [1:0] press;
    logic [1:0] rel;
  } ev_t;
  ev_t exp_q[$];

  button_debouncer #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic expect_ev(input int e, input logic [1:0] p, input logic [1:0] r);
    exp_q.push_back('{edge_no: e, press: p, rel: r});
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  // Every pulse, and every predicted pulse whose edge has come, is matched against the queue head.
  always @(negedge clk) begin
    if (rst_n && ((btn_press | btn_release) != 2'b00 ||
                  (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt))) begin
      ev_t e;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '{edge_no: -1, press: 2'b00, rel: 2'b00};
      checks++;
      assert ({edge_cnt, btn_press, btn_release} === {e.edge_no, e.press, e.rel}) else begin
        failures++;
        $error("FAIL event: observed edge=%0d press=%b release=%b expected edge=%0d press=%b release=%b",
               edge_cnt, btn_press, btn_release, e.edge_no, e.press, e.rel);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int f;
    int f1;
    int e0;
    rst_n   = 1'b0;
    btn_raw = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_level", btn_level, 2'b00);
    chk("reset_press", btn_press, 2'b00);
    chk("reset_release", btn_release, 2'b00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press on channel 0
    @(negedge clk);
    btn_raw[0] = 1'b1;
    k = edge_cnt + 1;
    expect_ev(k + 6, 2'b01, 2'b00);
    repeat (6) @(negedge clk);
    chk("t1_level_not_early", btn_level, 2'b00);
    @(negedge clk);
    chk("t1_level_on", btn_level, 2'b01);
    @(negedge clk);
    chk("t1_level_hold", btn_level, 2'b01);

    // Release with a one-cycle glitch back to 1
    btn_raw[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_level_before_glitch", btn_level, 2'b01);
    btn_raw[0] = 1'b1;
    @(negedge clk);
    btn_raw[0] = 1'b0;
    f = edge_cnt + 1;
    expect_ev(f + 6, 2'b00, 2'b01);
    repeat (5) @(negedge clk);
    chk("t3_level_through_glitch", btn_level, 2'b01);
    repeat (2) @(negedge clk);
    chk("t3_level_released", btn_level, 2'b00);
    repeat (2) @(negedge clk);

    // Bounce 1,0,1,0,1 with 2-cycle phases, then hold
    btn_raw[0] = 1'b1; repeat (2) @(negedge clk);
    btn_raw[0] = 1'b0; repeat (2) @(negedge clk);
    btn_raw[0] = 1'b1; repeat (2) @(negedge clk);
    btn_raw[0] = 1'b0; repeat (2) @(negedge clk);
    btn_raw[0] = 1'b1;
    k = edge_cnt + 1;
    expect_ev(k + 6, 2'b01, 2'b00);
    repeat (6) @(negedge clk);
    chk("t2_level_not_early", btn_level, 2'b00);
    @(negedge clk);
    chk("t2_level_on", btn_level, 2'b01);
    btn_raw[0] = 1'b0;
    f = edge_cnt + 1;
    expect_ev(f + 6, 2'b00, 2'b01);
    repeat (8) @(negedge clk);
    chk("t2_level_released", btn_level, 2'b00);

    // Simultaneous press, staggered releases
    btn_raw = 2'b11;
    k = edge_cnt + 1;
    expect_ev(k + 6, 2'b11, 2'b00);
    repeat (7) @(negedge clk);
    chk("t4_level_both", btn_level, 2'b11);
    btn_raw[0] = 1'b0;
    f = edge_cnt + 1;
    expect_ev(f + 6, 2'b00, 2'b01);
    repeat (2) @(negedge clk);
    btn_raw[1] = 1'b0;
    f1 = edge_cnt + 1;
    expect_ev(f1 + 6, 2'b00, 2'b10);
    repeat (5) @(negedge clk);
    chk("t4_level_ch1_only", btn_level, 2'b10);
    repeat (4) @(negedge clk);
    chk("t4_level_none", btn_level, 2'b00);

    // Reset while channel 1 is pressed and still held
    btn_raw[1] = 1'b1;
    k = edge_cnt + 1;
    expect_ev(k + 6, 2'b10, 2'b00);
    repeat (8) @(negedge clk);
    chk("t5_level_before_reset", btn_level, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_level_in_reset", btn_level, 2'b00);
    chk("t5_press_in_reset", btn_press, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = edge_cnt + 1;
    expect_ev(k + 6, 2'b10, 2'b00);
    repeat (6) @(negedge clk);
    chk("t5_level_not_early", btn_level, 2'b00);
    @(negedge clk);
    chk("t5_level_repressed", btn_level, 2'b10);
    btn_raw[1] = 1'b0;
    f = edge_cnt + 1;
    expect_ev(f + 6, 2'b00, 2'b10);
    repeat (8) @(negedge clk);
    chk("t5_level_released", btn_level, 2'b00);

    // Long hold on channel 0
    btn_raw[0] = 1'b1;
    k  = edge_cnt + 1;
    e0 = k + 6;
    expect_ev(e0, 2'b01, 2'b00);
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
    for (int o = 10; o <= 28; o += 3) expect_ev(e0 + o, 2'b01, 2'b00);
`endif
    while (edge_cnt < e0 + 28) @(negedge clk);
    chk("t6_level_held", btn_level, 2'b01);
    btn_raw[0] = 1'b0;
    f = edge_cnt + 1;
    expect_ev(f + 6, 2'b00, 2'b01);
    repeat (8) @(negedge clk);
    chk("t6_level_released", btn_level, 2'b00);

    repeat (3) @(negedge clk);
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL drain: observed pending=%0d expected pending=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
